// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin bus arbiter:
// FSM state encoding, requester indices and the default hold limit.
package bus_arbiter4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] REQ_IFETCH = 2'd0;
    localparam logic [1:0] REQ_DMEM   = 2'd1;
    localparam logic [1:0] REQ_DMA    = 2'd2;
    localparam logic [1:0] REQ_DBG    = 2'd3;

    localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request scanning
// last+1, last+2, last+3, last (mod 4).
module rr_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = last;
        any    = |req;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for the shared 32-bit datapath. Grants one requester
// at a time, holding until done, owner drop, or the hold limit expires.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);

    // CNT_W must be wide enough that MAX_HOLD-1 is reachable before saturation.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       winner;
    logic             any;
    logic             owner_req;
    logic             limit_hit;
    logic             release_now;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    // sel holds the owner throughout BUSY, so it doubles as the owner index.
    assign owner_req   = req[sel];
    assign limit_hit   = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    assign release_now = done || !owner_req || limit_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt     <= 4'b0000;
            sel     <= 2'd0;
            busy    <= 1'b0;
            preempt <= 1'b0;
            cnt     <= '0;
            last    <= 2'd3;
        end else begin
            case (state)
                ST_IDLE: begin
                    preempt <= 1'b0;
                    if (any) begin
                        gnt   <= 4'b0001 << winner;
                        sel   <= winner;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (release_now) begin
                        gnt     <= 4'b0000;
                        busy    <= 1'b0;
                        last    <= sel;
                        preempt <= limit_hit && !done && owner_req;
                        state   <= ST_IDLE;
                    end else begin
                        preempt <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: four instances with different hold limits share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_bus_arbiter4;

    localparam int MH_TAB [4] = '{16, 4, 2, 0};

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       chk_en;

    logic [3:0] gnt_w  [4];
    logic [1:0] sel_w  [4];
    logic       busy_w [4];
    logic       pre_w  [4];

    int n_cmp;
    int n_bad;

    // model: whether a grant is live, who owns it, how many BUSY cycles it has had
    bit m_busy  [4];
    bit m_pre   [4];
    int m_owner [4];
    int m_last  [4];
    int m_sel   [4];
    int m_held  [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bus_arbiter4 #(.MAX_HOLD(MH_TAB[g]), .CNT_W(5)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req     (req),
            .done    (done),
            .gnt     (gnt_w[g]),
            .sel     (sel_w[g]),
            .busy    (busy_w[g]),
            .preempt (pre_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_win(logic [3:0] r, int lst);
        for (int j = 1; j <= 4; j++) begin
            if (r[(lst + j) % 4]) return (lst + j) % 4;
        end
        return lst;
    endfunction

    function automatic int exp_gnt(int k);
        return m_busy[k] ? (1 << m_owner[k]) : 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0;
                m_pre[k]  <= 1'b0;
                m_sel[k]  <= 0;
                m_last[k] <= 3;
                m_held[k] <= 0;
            end else if (!m_busy[k]) begin
                m_pre[k] <= 1'b0;
                if (req != 4'b0000) begin
                    m_busy[k]  <= 1'b1;
                    m_owner[k] <= rr_win(req, m_last[k]);
                    m_sel[k]   <= rr_win(req, m_last[k]);
                    m_held[k]  <= 0;
                end
            end else begin
                m_held[k] <= m_held[k] + 1;
                if (done || !req[m_owner[k]] ||
                    (MH_TAB[k] != 0 && m_held[k] + 1 == MH_TAB[k])) begin
                    m_busy[k] <= 1'b0;
                    m_last[k] <= m_owner[k];
                    // only the hold limit can end a grant with done low and req still up
                    m_pre[k]  <= !done && req[m_owner[k]];
                end else begin
                    m_pre[k] <= 1'b0;
                end
            end
        end
    end

    task automatic cmp(string nm, int k, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                cmp("gnt", k, int'(gnt_w[k]), exp_gnt(k));
                cmp("sel", k, int'(sel_w[k]), m_sel[k]);
                cmp("busy", k, int'(busy_w[k]), int'(m_busy[k]));
                cmp("preempt", k, int'(pre_w[k]), int'(m_pre[k]));
            end
        end
    end

    // literal expectation checked against both the DUT and the model
    task automatic lit(string nm, int k, int eg, int es, int eb, int ep);
        cmp({nm, "_gnt"}, k, int'(gnt_w[k]), eg);
        cmp({nm, "_sel"}, k, int'(sel_w[k]), es);
        cmp({nm, "_busy"}, k, int'(busy_w[k]), eb);
        cmp({nm, "_pre"}, k, int'(pre_w[k]), ep);
        cmp({nm, "_model"}, k, (exp_gnt(k) << 8) | (m_sel[k] << 4) | (int'(m_busy[k]) << 1) | int'(m_pre[k]),
            (eg << 8) | (es << 4) | (eb << 1) | ep);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int rr_g [9];
        int rr_s [9];
        int dprob;
        int fprob;
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;
        step();
        chk_en = 1'b1;
        lit("reset", 0, 0, 0, 0, 0);
        step();

        // single request, done, regrant
        rst = 1'b0; req = 4'b0001;
        step();
        lit("single_gnt", 0, 1, 0, 1, 0);
        lit("single_gnt", 3, 1, 0, 1, 0);
        done = 1'b1;
        step();
        lit("single_rel", 0, 0, 0, 0, 0);
        done = 1'b0;
        step();
        lit("single_regnt", 0, 1, 0, 1, 0);

        // hold limit on the MAX_HOLD=4 instance
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b0110;
        step();
        lit("hold_c1", 1, 2, 1, 1, 0);
        for (int c = 2; c <= 4; c++) begin
            step();
            lit("hold_cn", 1, 2, 1, 1, 0);
        end
        step();
        lit("hold_preempt", 1, 0, 1, 0, 1);
        step();
        lit("hold_next", 1, 4, 2, 1, 0);

        // owner 2 drops its request; next scan starts at 3
        req = 4'b1011;
        step();
        lit("drop_rel", 1, 0, 2, 0, 0);
        step();
        lit("drop_next", 1, 8, 3, 1, 0);

        // reset while requester 3 owns the bus
        rst = 1'b1; req = 4'b1001;
        step();
        lit("rst_mid", 1, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        lit("rst_after", 1, 1, 0, 1, 0);

        // done coinciding with the limit on the MAX_HOLD=2 instance
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b0001;
        step();
        lit("sim_c1", 2, 1, 0, 1, 0);
        step();
        lit("sim_c2", 2, 1, 0, 1, 0);
        done = 1'b1;
        step();
        lit("sim_rel", 2, 0, 0, 0, 0);
        done = 1'b0;

        // rotation with all requesting and done held high
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b1111; done = 1'b1;
        rr_g = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
        rr_s = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        for (int i = 0; i < 9; i++) begin
            step();
            lit("rr", 0, rr_g[i], rr_s[i], (rr_g[i] != 0) ? 1 : 0, 0);
        end
        done = 1'b0;

        // randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            dprob = (cyc < 2000) ? 5 : 30;
            fprob = (cyc < 2000) ? 7 : 20;
            rst = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, fprob) == 0) req[b] = ~req[b];
            end
            done = ($urandom_range(0, dprob) == 0);
            step();
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
